// File: rtl/riscv_mem_pkg.sv
// Shared types for the RV64 store buffer: FSM states, queued entry layout and the
// doubleword overlap test used when a load is checked against the queued stores.
package riscv_mem_pkg;

    localparam int SB_ADDR_W   = 64;
    localparam int SB_DATA_W   = 64;
    localparam int DWORD_BYTES = 8;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HAZARD = 2'd1,
        FLUSH  = 2'd2
    } sb_state_e;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

    // Two doubleword accesses share a byte when their start addresses lie within 8 bytes either way.
    function automatic logic dword_overlap(input logic [SB_ADDR_W-1:0] a, input logic [SB_ADDR_W-1:0] b);
        logic [SB_ADDR_W-1:0] d_ab;
        logic [SB_ADDR_W-1:0] d_ba;
        d_ab = a - b;
        d_ba = b - a;
        return (d_ab < SB_ADDR_W'(DWORD_BYTES)) || (d_ba < SB_ADDR_W'(DWORD_BYTES));
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Signal bundle between the MEM stage / Data_Memory (master) and the store buffer (slave).
interface store_buffer_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 3
);
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              stall;
    logic              flush;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, flush, mem_rdata,
        input  st_ready, ld_data, stall, empty, count, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, flush, mem_rdata,
        output st_ready, ld_data, stall, empty, count, mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/store_buffer_fifo.sv
// Store queue: circular storage, pointers, occupancy, and per-entry load overlap / exact-match
// vectors presented in age order (index 0 is the head, the oldest store).
module store_buffer_fifo
    import riscv_mem_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_push,
    input  sb_entry_t            i_push_entry,
    input  logic                 i_pop,
    input  logic [SB_ADDR_W-1:0] i_ld_addr,
    output sb_entry_t            o_entries [DEPTH],
    output logic [DEPTH-1:0]     o_ovl,
    output logic [DEPTH-1:0]     o_match,
    output logic [CNT_W-1:0]     o_count,
    output logic                 o_empty,
    output logic                 o_full
);

    sb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_count = r_count;
    assign o_empty = (r_count == CNT_W'(0));
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    // Age-ordered view of the queue with overlap/match flags gated by entry validity.
    always_comb begin
        o_ovl   = '0;
        o_match = '0;
        for (int k = 0; k < DEPTH; k++) begin
            o_entries[k] = r_mem[r_rd_ptr + PTR_W'(k)];
            if (CNT_W'(k) < r_count) begin
                o_ovl[k]   = dword_overlap(i_ld_addr, r_mem[r_rd_ptr + PTR_W'(k)].addr);
                o_match[k] = (i_ld_addr == r_mem[r_rd_ptr + PTR_W'(k)].addr);
            end else begin
                o_ovl[k]   = 1'b0;
                o_match[k] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer top: RUN/HAZARD/FLUSH control and load/drain arbitration of the Data_Memory port.
// Build option STORE_FWD_EN: exact-address loads take data from the youngest matching queued store.
module store_buffer
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    sb_state_e         r_state;
    sb_state_e         w_state_next;
    sb_entry_t         w_push_entry;
    sb_entry_t         w_entries [DEPTH];
    logic [DEPTH-1:0]  w_ovl;
    logic [DEPTH-1:0]  w_match;
    logic [CNT_W-1:0]  w_count;
    logic              w_empty;
    logic              w_full;
    logic              w_st_ready;
    logic              w_push;
    logic              w_fwd_ok;
    logic [DATA_W-1:0] w_fwd_data;
    logic              w_hazard;
    logic              w_tail_ovl;
    logic              w_mem_read;
    logic              w_mem_write;
    logic              w_stall;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_ld_data;

    // New stores are refused while full or while a drain is requested or in progress.
    assign w_st_ready   = !w_full && (r_state != FLUSH) && !bus.flush;
    assign w_push       = bus.st_valid && w_st_ready;
    assign w_push_entry = '{addr: bus.st_addr, data: bus.st_data};

    store_buffer_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_mem_write),
        .i_ld_addr    (bus.ld_addr),
        .o_entries    (w_entries),
        .o_ovl        (w_ovl),
        .o_match      (w_match),
        .o_count      (w_count),
        .o_empty      (w_empty),
        .o_full       (w_full)
    );

    // Classify the load: forwardable exact hit, or a hazard that has to wait for the drain.
    always_comb begin
        w_fwd_ok   = 1'b0;
        w_fwd_data = '0;
`ifdef STORE_FWD_EN
        if (bus.ld_valid && (w_match != '0) && ((w_ovl & ~w_match) == '0)) begin
            w_fwd_ok = 1'b1;
        end else begin
            w_fwd_ok = 1'b0;
        end
        for (int k = 0; k < DEPTH; k++) begin
            w_fwd_data = w_match[k] ? w_entries[k].data : w_fwd_data;
        end
`endif
        w_hazard   = bus.ld_valid && ((w_ovl | w_match) != '0) && !w_fwd_ok;
        w_tail_ovl = bus.ld_valid && ((w_ovl >> 1) != '0);
    end

    // Port arbitration and next state; reset holds the port idle so nothing retires during it.
    always_comb begin
        w_state_next = r_state;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_stall      = 1'b0;
        w_ld_data    = '0;
        if (reset) begin
            w_state_next = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_hazard) begin
                        w_stall      = 1'b1;
                        w_mem_write  = !w_empty;
                        w_state_next = HAZARD;
                    end else if (bus.ld_valid) begin
                        if (w_fwd_ok) begin
                            w_ld_data = w_fwd_data;
                        end else begin
                            w_mem_read = 1'b1;
                            w_ld_data  = bus.mem_rdata;
                        end
                        w_state_next = bus.flush ? FLUSH : RUN;
                    end else begin
                        w_mem_write  = !w_empty;
                        w_state_next = bus.flush ? FLUSH : RUN;
                    end
                end
                HAZARD: begin
                    // The head leaves this cycle, so only younger overlapping entries keep us here.
                    w_stall      = 1'b1;
                    w_mem_write  = !w_empty;
                    w_state_next = w_tail_ovl ? HAZARD : RUN;
                end
                FLUSH: begin
                    w_stall      = 1'b1;
                    w_mem_write  = !w_empty;
                    w_state_next = (w_empty && !bus.flush) ? RUN : FLUSH;
                end
                default: begin
                    w_state_next = RUN;
                end
            endcase
        end
    end

    // Memory address/data mux; the bus is driven to zero when the port is idle.
    always_comb begin
        if (w_mem_write) begin
            w_mem_addr  = w_entries[0].addr;
            w_mem_wdata = w_entries[0].data;
        end else if (w_mem_read) begin
            w_mem_addr  = bus.ld_addr;
            w_mem_wdata = '0;
        end else begin
            w_mem_addr  = '0;
            w_mem_wdata = '0;
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign bus.st_ready  = w_st_ready;
    assign bus.ld_data   = w_ld_data;
    assign bus.stall     = w_stall;
    assign bus.empty     = w_empty;
    assign bus.count     = w_count;
    assign bus.mem_read  = w_mem_read;
    assign bus.mem_write = w_mem_write;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a byte-addressed Data_Memory model behind the port.
module tb_store_buffer;
    import riscv_mem_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic reset;
    logic mem_clear;
    int   errors;
    int   checks;

    always #5 clk = ~clk;

    store_buffer_if #(.ADDR_W(64), .DATA_W(64), .CNT_W(CNT_W)) bus ();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [7:0] mem_b [0:1023];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem_b[i] <= 8'h00;
        end else if (bus.mem_write) begin
            for (int i = 0; i < 8; i++) mem_b[bus.mem_addr[9:0] + 10'(i)] <= bus.mem_wdata[8*i +: 8];
        end
    end

    always_comb begin
        bus.mem_rdata = '0;
        for (int i = 0; i < 8; i++) bus.mem_rdata[8*i +: 8] = mem_b[bus.mem_addr[9:0] + 10'(i)];
    end

    function automatic logic [63:0] model_dword(input logic [9:0] a);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = mem_b[a + 10'(i)];
        return r;
    endfunction

    task automatic idle();
        bus.st_valid = 1'b0;
        bus.st_addr  = 64'h0;
        bus.st_data  = 64'h0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = 64'h0;
        bus.flush    = 1'b0;
    endtask

    task automatic put_store(input logic [63:0] a, input logic [63:0] d);
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_data  = d;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready: got %b want 1", bus.st_ready); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
        checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_ctl: got rd=%b wr=%b want 0/0", bus.mem_read, bus.mem_write); end
        checks++; if (bus.ld_data !== 64'h0 || bus.mem_addr !== 64'h0) begin errors++; $display("FAIL reset_buses: got ld_data=%h mem_addr=%h want 0/0", bus.ld_data, bus.mem_addr); end
    endtask

    task automatic test_single_store();
        @(negedge clk); put_store(64'h10, 64'hAA); #1;
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL single_no_early_write: got %b want 0", bus.mem_write); end
        @(negedge clk); bus.st_valid = 1'b0; #1;
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_addr !== 64'h10 || bus.mem_wdata !== 64'hAA) begin
            errors++; $display("FAIL single_retire: got wr=%b addr=%h data=%h want 1/10/aa", bus.mem_write, bus.mem_addr, bus.mem_wdata); end
        checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", bus.count); end
        @(negedge clk); #1;
        checks++; if (bus.empty !== 1'b1 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL single_empty: got empty=%b wr=%b want 1/0", bus.empty, bus.mem_write); end
        checks++; if (model_dword(10'h10) !== 64'hAA) begin errors++; $display("FAIL single_mem: got %h want aa", model_dword(10'h10)); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); put_store(64'hA0 + 64'(8*i), 64'hB0 + 64'(i)); #1;
            if (i > 0) begin
                checks++; if (bus.mem_write !== 1'b1 || bus.mem_addr !== 64'hA0 + 64'(8*(i-1)) || bus.count !== 3'd1) begin
                    errors++; $display("FAIL b2b_retire%0d: got wr=%b addr=%h count=%0d want 1/%h/1", i, bus.mem_write, bus.mem_addr, bus.count, 64'hA0 + 64'(8*(i-1))); end
            end
        end
        @(negedge clk); bus.st_valid = 1'b0; #1;
        checks++; if (bus.mem_addr !== 64'hB8 || bus.mem_wdata !== 64'hB3) begin errors++; $display("FAIL b2b_last: got addr=%h data=%h want b8/b3", bus.mem_addr, bus.mem_wdata); end
        @(negedge clk); #1;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_full_order();
        @(negedge clk); bus.ld_valid = 1'b1; bus.ld_addr = 64'h100;
        for (int i = 0; i < 4; i++) begin
            put_store(64'h40 + 64'(8*i), 64'h1000 + 64'(i));
            @(negedge clk);
        end
        put_store(64'h200, 64'hDEAD); #1;
        checks++; if (bus.count !== 3'd4 || bus.st_ready !== 1'b0) begin errors++; $display("FAIL full_state: got count=%0d st_ready=%b want 4/0", bus.count, bus.st_ready); end
        checks++; if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b1 || bus.stall !== 1'b0) begin
            errors++; $display("FAIL full_load_served: got wr=%b rd=%b stall=%b want 0/1/0", bus.mem_write, bus.mem_read, bus.stall); end
        @(negedge clk); #1;
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL full_no_overwrite: got %0d want 4", bus.count); end
        bus.st_valid = 1'b0; bus.ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.mem_write !== 1'b1 || bus.mem_addr !== 64'h40 + 64'(8*i) || bus.mem_wdata !== 64'h1000 + 64'(i)) begin
                errors++; $display("FAIL full_order%0d: got wr=%b addr=%h data=%h want 1/%h/%h", i, bus.mem_write, bus.mem_addr, bus.mem_wdata, 64'h40 + 64'(8*i), 64'h1000 + 64'(i)); end
            @(negedge clk);
        end
        #1;
        checks++; if (bus.empty !== 1'b1 || model_dword(10'h200) !== 64'h0) begin errors++; $display("FAIL full_drained: got empty=%b mem200=%h want 1/0", bus.empty, model_dword(10'h200)); end
    endtask

    task automatic test_partial_hazard();
        @(negedge clk); put_store(64'h20, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk); bus.st_valid = 1'b0;
        @(negedge clk); bus.ld_valid = 1'b1; bus.ld_addr = 64'h100; put_store(64'h20, 64'h1234);
        @(negedge clk); bus.st_valid = 1'b0; bus.ld_addr = 64'h24; #1;
        checks++; if (bus.stall !== 1'b1 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL partial_stall: got stall=%b rd=%b want 1/0", bus.stall, bus.mem_read); end
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_wdata !== 64'h1234) begin errors++; $display("FAIL partial_drain: got wr=%b data=%h want 1/1234", bus.mem_write, bus.mem_wdata); end
        @(negedge clk); #1;
        checks++; if (bus.stall !== 1'b1 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL partial_hazard_cycle: got stall=%b wr=%b want 1/0", bus.stall, bus.mem_write); end
        @(negedge clk); #1;
        checks++; if (bus.stall !== 1'b0 || bus.mem_read !== 1'b1 || bus.ld_data !== 64'h0) begin
            errors++; $display("FAIL partial_load: got stall=%b rd=%b ld_data=%h want 0/1/0", bus.stall, bus.mem_read, bus.ld_data); end
        @(negedge clk); bus.ld_valid = 1'b0;
    endtask

    task automatic test_forward();
        @(negedge clk); bus.ld_valid = 1'b1; bus.ld_addr = 64'h100; put_store(64'h08, 64'h11);
        @(negedge clk); put_store(64'h08, 64'h22);
        @(negedge clk); bus.st_valid = 1'b0; bus.ld_addr = 64'h08; #1;
`ifdef STORE_FWD_EN
        checks++; if (bus.ld_data !== 64'h22 || bus.stall !== 1'b0 || bus.mem_read !== 1'b0) begin
            errors++; $display("FAIL fwd_hit: got ld_data=%h stall=%b rd=%b want 22/0/0", bus.ld_data, bus.stall, bus.mem_read); end
        @(negedge clk); bus.ld_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (bus.empty !== 1'b1 || model_dword(10'h08) !== 64'h22) begin errors++; $display("FAIL fwd_drain: got empty=%b mem=%h want 1/22", bus.empty, model_dword(10'h08)); end
`else
        checks++; if (bus.stall !== 1'b1 || bus.mem_write !== 1'b1 || bus.mem_wdata !== 64'h11) begin
            errors++; $display("FAIL exact_stall1: got stall=%b wr=%b data=%h want 1/1/11", bus.stall, bus.mem_write, bus.mem_wdata); end
        @(negedge clk); #1;
        checks++; if (bus.stall !== 1'b1 || bus.mem_write !== 1'b1 || bus.mem_wdata !== 64'h22) begin
            errors++; $display("FAIL exact_stall2: got stall=%b wr=%b data=%h want 1/1/22", bus.stall, bus.mem_write, bus.mem_wdata); end
        @(negedge clk); #1;
        checks++; if (bus.stall !== 1'b0 || bus.mem_read !== 1'b1 || bus.ld_data !== 64'h22) begin
            errors++; $display("FAIL exact_load: got stall=%b rd=%b ld_data=%h want 0/1/22", bus.stall, bus.mem_read, bus.ld_data); end
        @(negedge clk); bus.ld_valid = 1'b0;
`endif
    endtask

    task automatic test_flush();
        @(negedge clk); bus.ld_valid = 1'b1; bus.ld_addr = 64'h100; put_store(64'h60, 64'h5);
        @(negedge clk); put_store(64'h68, 64'h6);
        @(negedge clk); put_store(64'h70, 64'h7);
        @(negedge clk); bus.ld_valid = 1'b0; bus.flush = 1'b1; put_store(64'h300, 64'h99); #1;
        checks++; if (bus.st_ready !== 1'b0) begin errors++; $display("FAIL flush_st_ready: got %b want 0", bus.st_ready); end
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.mem_write !== 1'b1 || bus.mem_addr !== 64'h60 + 64'(8*i)) begin
                errors++; $display("FAIL flush_retire%0d: got wr=%b addr=%h want 1/%h", i, bus.mem_write, bus.mem_addr, 64'h60 + 64'(8*i)); end
            @(negedge clk);
        end
        #1;
        checks++; if (bus.empty !== 1'b1 || bus.stall !== 1'b1 || bus.st_ready !== 1'b0) begin
            errors++; $display("FAIL flush_hold: got empty=%b stall=%b st_ready=%b want 1/1/0", bus.empty, bus.stall, bus.st_ready); end
        bus.flush = 1'b0; bus.st_valid = 1'b0;
        @(negedge clk); #1;
        checks++; if (bus.stall !== 1'b0 || bus.count !== 3'd0 || bus.st_ready !== 1'b1) begin
            errors++; $display("FAIL flush_exit: got stall=%b count=%0d st_ready=%b want 0/0/1", bus.stall, bus.count, bus.st_ready); end
        checks++; if (model_dword(10'h70) !== 64'h7 || model_dword(10'h300) !== 64'h0) begin
            errors++; $display("FAIL flush_mem: got m70=%h m300=%h want 7/0", model_dword(10'h70), model_dword(10'h300)); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); bus.ld_valid = 1'b1; bus.ld_addr = 64'h100; put_store(64'h80, 64'h1);
        @(negedge clk); put_store(64'h88, 64'h2);
        @(negedge clk); put_store(64'h90, 64'h3);
        @(negedge clk); bus.st_valid = 1'b0; #1;
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL rst_mid_count_before: got %0d want 3", bus.count); end
        reset = 1'b1; bus.ld_valid = 1'b0; #1;
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL rst_mid_no_write: got %b want 0", bus.mem_write); end
        @(negedge clk); reset = 1'b0; #1;
        checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.mem_write !== 1'b0) begin
            errors++; $display("FAIL rst_mid_after: got count=%0d empty=%b wr=%b want 0/1/0", bus.count, bus.empty, bus.mem_write); end
        checks++; if (model_dword(10'h80) !== 64'h0) begin errors++; $display("FAIL rst_mid_mem: got %h want 0", model_dword(10'h80)); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        idle();
        reset     = 1'b1;
        mem_clear = 1'b1;
        repeat (3) @(negedge clk);
        reset     = 1'b0;
        mem_clear = 1'b0;
        test_reset();
        test_single_store();
        test_back_to_back();
        test_full_order();
        test_partial_hazard();
        test_forward();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
